// File: rtl/dpll_loop_ctrl.sv
// Purpose: DPLL loop controller; windows the PFD UP/DOWN flags, steers the DCO word, declares lock.
// Latency: flags see a 2-cycle synchronizer; dco_word/state/locked update on the edge after a window's last cycle.
// Backpressure: none; free-running. Optional DPLL_CTRL_FREEZE_EN adds a `freeze` input that holds the loop.
module dpll_loop_ctrl #(
  parameter int unsigned      DCO_W       = 12,
  parameter logic [DCO_W-1:0] DCO_INIT    = 'h800,
  parameter int unsigned      WIN_LEN     = 64,
  parameter int unsigned      COARSE_STEP = 16,
  parameter int unsigned      LOCK_TOL    = 2,
  parameter int unsigned      UNLOCK_TOL  = 8,
  parameter int unsigned      LOCK_CNT    = 4,
  parameter int unsigned      PFD_RST_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             enable,
`ifdef DPLL_CTRL_FREEZE_EN
  input  logic             freeze,
`endif
  input  logic             flagu,
  input  logic             flagd,
  output logic             pfd_rst,
  output logic [DCO_W-1:0] dco_word,
  output logic             locked,
  output logic [2:0]       state
);

  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int WW = $clog2(WIN_LEN);
  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(PFD_RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PFD_RST = 3'd1,
    S_COARSE  = 3'd2,
    S_FINE    = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t           st, st_nxt;
  logic [DCO_W-1:0] dco_nxt;
  logic             locked_nxt;
  logic [QW-1:0]    qcnt, qcnt_nxt;
  logic             ld_vld, ld_vld_nxt;
  logic             ld_neg, ld_neg_nxt;

  logic             fu_s1, fu_s2, fd_s1, fd_s2;
  logic [WW-1:0]    win_cnt;
  logic [CW-1:0]    up_cnt, dn_cnt;
  logic [RW-1:0]    rst_cnt;

  logic             up_hit, dn_hit, running, win_end, hold;
  logic [CW-1:0]    up_tot, dn_tot;
  logic signed [CW:0] diff;
  logic [CW:0]      mag;
  logic             neg, quiet, big;

  logic                     do_step;
  logic signed [DCO_W+1:0]  step_mag;
  logic signed [DCO_W+1:0]  sum;

  // Window arithmetic; the evaluate cycle's own sample is folded in here.
  always_comb begin
    up_hit  = fu_s2 & ~fd_s2;
    dn_hit  = fd_s2 & ~fu_s2;
    running = (st == S_COARSE) || (st == S_FINE) || (st == S_LOCKED);
    win_end = running && (win_cnt == WW'(WIN_LEN - 1));
    up_tot  = up_cnt + CW'(up_hit);
    dn_tot  = dn_cnt + CW'(dn_hit);
    diff    = $signed({1'b0, up_tot}) - $signed({1'b0, dn_tot});
    neg     = diff[CW];
    mag     = neg ? $unsigned(-diff) : $unsigned(diff);
    quiet   = (mag <= (CW+1)'(LOCK_TOL));
    big     = (mag > (CW+1)'(UNLOCK_TOL));
`ifdef DPLL_CTRL_FREEZE_EN
    hold    = freeze;
`else
    hold    = 1'b0;
`endif
  end

  // Next-state, lock, quiet-run and DCO-step decisions; saturating DCO update.
  always_comb begin
    st_nxt     = st;
    dco_nxt    = dco_word;
    locked_nxt = locked;
    qcnt_nxt   = qcnt;
    ld_vld_nxt = ld_vld;
    ld_neg_nxt = ld_neg;
    do_step    = 1'b0;
    step_mag   = (DCO_W+2)'(1);
    sum        = '0;
    if (!enable) begin
      st_nxt     = S_IDLE;
      dco_nxt    = DCO_INIT;
      locked_nxt = 1'b0;
      qcnt_nxt   = '0;
      ld_vld_nxt = 1'b0;
      ld_neg_nxt = 1'b0;
    end else if (!hold) begin
      case (st)
        S_IDLE:    st_nxt = S_PFD_RST;
        S_PFD_RST: if (rst_cnt == RW'(PFD_RST_CYC - 1)) st_nxt = S_COARSE;
        S_COARSE: begin
          if (win_end && !quiet) begin
            do_step    = 1'b1;
            ld_vld_nxt = 1'b1;
            ld_neg_nxt = neg;
            // A direction reversal means we overshot: hand over to fine steps.
            if (ld_vld && (ld_neg != neg)) st_nxt = S_FINE;
            else step_mag = (DCO_W+2)'(COARSE_STEP);
          end
        end
        S_FINE: begin
          if (win_end) begin
            if (quiet) begin
              qcnt_nxt = qcnt + QW'(1);
              if (qcnt == QW'(LOCK_CNT - 1)) begin
                st_nxt     = S_LOCKED;
                locked_nxt = 1'b1;
              end
            end else begin
              do_step  = 1'b1;
              qcnt_nxt = '0;
            end
          end
        end
        S_LOCKED: begin
          if (win_end && !quiet) begin
            do_step = 1'b1;
            if (big) begin
              st_nxt     = S_FINE;
              locked_nxt = 1'b0;
              qcnt_nxt   = '0;
            end
          end
        end
        default: st_nxt = S_IDLE;
      endcase
      if (do_step) begin
        sum = neg ? ($signed({2'b00, dco_word}) - step_mag)
                  : ($signed({2'b00, dco_word}) + step_mag);
        if (sum[DCO_W+1])   dco_nxt = '0;
        else if (sum[DCO_W]) dco_nxt = '1;
        else                 dco_nxt = sum[DCO_W-1:0];
      end
    end
  end

  // Loop state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st       <= S_IDLE;
      dco_word <= DCO_INIT;
      locked   <= 1'b0;
      qcnt     <= '0;
      ld_vld   <= 1'b0;
      ld_neg   <= 1'b0;
    end else begin
      st       <= st_nxt;
      dco_word <= dco_nxt;
      locked   <= locked_nxt;
      qcnt     <= qcnt_nxt;
      ld_vld   <= ld_vld_nxt;
      ld_neg   <= ld_neg_nxt;
    end
  end

  // Flag synchronizers, PFD reset timer and window counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fu_s1   <= 1'b0;
      fu_s2   <= 1'b0;
      fd_s1   <= 1'b0;
      fd_s2   <= 1'b0;
      rst_cnt <= '0;
      win_cnt <= '0;
      up_cnt  <= '0;
      dn_cnt  <= '0;
    end else begin
      fu_s1 <= flagu;
      fu_s2 <= fu_s1;
      fd_s1 <= flagd;
      fd_s2 <= fd_s1;
      if (enable && (st == S_PFD_RST)) begin
        if (!hold) rst_cnt <= rst_cnt + RW'(1);
      end else begin
        rst_cnt <= '0;
      end
      // Windows keep running under freeze; only evaluations are discarded.
      if (!enable || !running || win_end) begin
        win_cnt <= '0;
        up_cnt  <= '0;
        dn_cnt  <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        up_cnt  <= up_tot;
        dn_cnt  <= dn_tot;
      end
    end
  end

  assign pfd_rst = (st == S_IDLE) || (st == S_PFD_RST);
  assign state   = st;

endmodule
